tracker_ctrl: RTL and testbench
===============================

TRACKER_CTRL -- requirements
Module: tracker_ctrl

Interface
REQ-001 SHALL: clk  input  1  single system clock; all state on rising edge; clk >= 4x camPclk.
REQ-002 SHALL: resetN  input  1  reset, asynchronous, active-low.
REQ-003 SHALL: camVsync, camHref, camPclk  input  1 each  raw camera strobes, asynchronous to clk.
REQ-004 SHALL: camData  input  8  camera RGB565 byte bus, sampled with camPclk.
REQ-005 SHALL: enable  input  1  run request.
REQ-006 SHALL: cfgValid  input  1, cfgReady  output  1  target-colour write handshake.
REQ-007 SHALL: cfgRed, cfgGreen, cfgBlue, cfgThreshold  input  8 each  requested target colour and match threshold.
REQ-008 SHALL: targetRed, targetGreen, targetBlue, threshold  output  8 each  active configuration to the tracking datapath.
REQ-009 SHALL: pixelValid  output  1, pixelRed/pixelGreen/pixelBlue  output  8 each, pixelX/pixelY  output  8 each  one assembled pixel per pulse.
REQ-010 SHALL: frameStart, frameDone  output  1 each  single-cycle frame pulses; busy  output  1  high outside IDLE.

Function
REQ-011 SHALL: pass camVsync, camHref, camPclk through 2-flop synchronizers, then edge-detect in clk domain; camData captured on the synchronized camPclk rising edge.
REQ-012 SHALL: FSM states IDLE, WAIT_VS, BLANK, LINE.
REQ-013 SHALL: IDLE -> WAIT_VS when enable=1; any state -> IDLE within 1 cycle of enable=0, with no further pixelValid/frameStart/frameDone.
REQ-014 SHALL: WAIT_VS -> BLANK on synced vsync rising edge (discards partial first frame).
REQ-015 SHALL: BLANK: synced vsync falling edge -> frameStart pulse, x=y=0, pending config applied in the same cycle.
REQ-016 SHALL: BLANK -> LINE on href rising edge while vsync low; byte phase cleared to 0, x=0.
REQ-017 SHALL: LINE: byte0 = R[4:0]G[5:3], byte1 = G[2:0]B[4:0]; after byte1, assemble the pixel.
REQ-018 SHALL: expansion: pixelRed = {R5,R5[4:2]}, pixelGreen = {G6,G6[5:4]}, pixelBlue = {B5,B5[4:2]}.
REQ-019 SHALL: pixelValid pulse 1 cycle after the byte1 capture cycle; pixel outputs hold until next pulse; pixelX/pixelY = coordinates of that pixel.
REQ-020 SHALL: x increments after each pixel, saturating at 255; y increments on href falling edge, saturating at 255.
REQ-021 SHALL: LINE -> BLANK on href falling edge; an unpaired byte0 is dropped silently.
REQ-022 SHALL: synced vsync rising edge in BLANK or LINE -> frameDone pulse; state BLANK.
REQ-023 SHALL: cfgReady = 1 when no update pending; cfgValid & cfgReady loads the shadow registers and sets pending; cfgReady = 0 while pending.
REQ-024 SHALL: pending update applies only at frameStart; targets never change mid-frame; pending then clears, so cfgReady returns to 1 the next cycle.
REQ-025 SHALL: accept coinciding with frameStart -> shadow loaded, applied at the following frameStart.
REQ-026 SHALL: a pending update survives enable=0 and applies at the first frameStart after re-enable.

Reset
REQ-027 SHALL: resetN low: state IDLE, synchronizers 0, x=y=0, byte phase 0, pending 0.
REQ-028 SHALL: resetN low: all pixel outputs 0, targets 0, threshold 20, all pulses 0, busy 0, cfgReady 1.
REQ-029 SHALL: reset mid-frame takes effect immediately; after release, the block waits in WAIT_VS for a full frame.

Structure
REQ-030 SHALL: shared package trackerPkg holds the state enumeration, SYNC_STAGES=2, COORD_MAX=255, and reset threshold 20.
REQ-031 SHALL: one sub-module, edge_sync (2-flop synchronizer plus rise/fall pulse outputs), instantiated for vsync, href and pclk.

Verification
REQ-032 SHALL: reset release, enable=1, one 4x2-pixel frame -> exactly one frameStart, 8 pixelValid pulses with (x,y) = (0..3, 0..1), one frameDone.
REQ-033 SHALL: bytes 0xF8,0x00 -> pixelRed=255, pixelGreen=0, pixelBlue=0; bytes 0x07,0xE0 -> 0,255,0; bytes 0x00,0x1F -> 0,0,255.
REQ-034 SHALL: cfg write 10/20/30/5 mid-frame -> targets unchanged until next frameStart, then 10/20/30/5; cfgReady low in between.
REQ-035 SHALL: 300-pixel line -> pixelX holds 255 for pixels 256-300; line with 3 bytes -> 1 pixelValid only.
REQ-036 SHALL: enable dropped mid-line -> no further pixelValid, no frameDone, busy=0 next cycle; resetN pulse mid-frame -> outputs at reset values, first frameStart only after a full vsync cycle.

Source files
------------

// File: rtl/tracker_ctrl_pkg.sv
// Shared types and constants for the camera tracker controller.
package trackerPkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_VS,
    BLANK,
    LINE
  } trackerState_e;

  localparam int unsigned SYNC_STAGES     = 2;
  localparam logic [7:0]  COORD_MAX       = 8'd255;
  localparam logic [7:0]  RESET_THRESHOLD = 8'd20;

  function automatic logic [7:0] expand5(input logic [4:0] v);
    return {v, v[4:2]};
  endfunction

  function automatic logic [7:0] expand6(input logic [5:0] v);
    return {v, v[5:4]};
  endfunction

  function automatic logic [7:0] satInc(input logic [7:0] v);
    return (v == COORD_MAX) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/tracker_ctrl_edge_sync.sv
// Multi-flop synchronizer for an asynchronous strobe, with rise/fall pulses
// derived from the synchronized level.
module edge_sync
  import trackerPkg::*;
#(
  parameter int unsigned STAGES = SYNC_STAGES
) (
  input  logic clk,
  input  logic resetN,
  input  logic raw,
  output logic sync,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] chain;
  logic              prev;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      chain <= '0;
      prev  <= 1'b0;
    end else begin
      chain <= {chain[STAGES-2:0], raw};
      prev  <= chain[STAGES-1];
    end
  end

  assign sync = chain[STAGES-1];
  assign rise = sync & ~prev;
  assign fall = ~sync & prev;

endmodule

// File: rtl/tracker_ctrl.sv
// Camera frame tracker front end: syncs camera strobes, assembles RGB565
// pixels with coordinates, and applies target-colour updates at frame start.
module tracker_ctrl
  import trackerPkg::*;
(
  input  logic       clk,
  input  logic       resetN,
  input  logic       camVsync,
  input  logic       camHref,
  input  logic       camPclk,
  input  logic [7:0] camData,
  input  logic       enable,
  input  logic       cfgValid,
  output logic       cfgReady,
  input  logic [7:0] cfgRed,
  input  logic [7:0] cfgGreen,
  input  logic [7:0] cfgBlue,
  input  logic [7:0] cfgThreshold,
  output logic [7:0] targetRed,
  output logic [7:0] targetGreen,
  output logic [7:0] targetBlue,
  output logic [7:0] threshold,
  output logic       pixelValid,
  output logic [7:0] pixelRed,
  output logic [7:0] pixelGreen,
  output logic [7:0] pixelBlue,
  output logic [7:0] pixelX,
  output logic [7:0] pixelY,
  output logic       frameStart,
  output logic       frameDone,
  output logic       busy
);

  logic vsyncSync, vsyncRise, vsyncFall;
  logic hrefSync, hrefRise, hrefFall;
  logic pclkSync, pclkRise, pclkFall;
  logic unusedSync;

  edge_sync #(.STAGES(SYNC_STAGES)) vsyncSyncInst (
    .clk(clk), .resetN(resetN), .raw(camVsync),
    .sync(vsyncSync), .rise(vsyncRise), .fall(vsyncFall)
  );

  edge_sync #(.STAGES(SYNC_STAGES)) hrefSyncInst (
    .clk(clk), .resetN(resetN), .raw(camHref),
    .sync(hrefSync), .rise(hrefRise), .fall(hrefFall)
  );

  edge_sync #(.STAGES(SYNC_STAGES)) pclkSyncInst (
    .clk(clk), .resetN(resetN), .raw(camPclk),
    .sync(pclkSync), .rise(pclkRise), .fall(pclkFall)
  );

  assign unusedSync = ^{hrefSync, pclkSync, pclkFall};

  trackerState_e state;
  logic [7:0]    x, y;
  logic          phase;
  logic [7:0]    byte0;
  logic          pending;
  logic [7:0]    shadowRed, shadowGreen, shadowBlue, shadowThreshold;

  assign cfgReady = ~pending;
  assign busy     = (state != IDLE);

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state           <= IDLE;
      x               <= '0;
      y               <= '0;
      phase           <= 1'b0;
      byte0           <= '0;
      pending         <= 1'b0;
      shadowRed       <= '0;
      shadowGreen     <= '0;
      shadowBlue      <= '0;
      shadowThreshold <= RESET_THRESHOLD;
      targetRed       <= '0;
      targetGreen     <= '0;
      targetBlue      <= '0;
      threshold       <= RESET_THRESHOLD;
      pixelValid      <= 1'b0;
      pixelRed        <= '0;
      pixelGreen      <= '0;
      pixelBlue       <= '0;
      pixelX          <= '0;
      pixelY          <= '0;
      frameStart      <= 1'b0;
      frameDone       <= 1'b0;
    end else begin
      pixelValid <= 1'b0;
      frameStart <= 1'b0;
      frameDone  <= 1'b0;

      // Config accept and frame-start apply are mutually exclusive on pending.
      if (cfgValid && !pending) begin
        shadowRed       <= cfgRed;
        shadowGreen     <= cfgGreen;
        shadowBlue      <= cfgBlue;
        shadowThreshold <= cfgThreshold;
        pending         <= 1'b1;
      end

      if (!enable) begin
        state <= IDLE;
      end else begin
        unique case (state)
          IDLE: state <= WAIT_VS;
          WAIT_VS: begin
            if (vsyncRise) state <= BLANK;
          end
          BLANK: begin
            if (vsyncRise) begin
              frameDone <= 1'b1;
            end else if (vsyncFall) begin
              frameStart <= 1'b1;
              x          <= '0;
              y          <= '0;
              if (pending) begin
                targetRed   <= shadowRed;
                targetGreen <= shadowGreen;
                targetBlue  <= shadowBlue;
                threshold   <= shadowThreshold;
                pending     <= 1'b0;
              end
            end else if (hrefRise && !vsyncSync) begin
              state <= LINE;
              phase <= 1'b0;
              x     <= '0;
            end
          end
          LINE: begin
            if (vsyncRise) begin
              frameDone <= 1'b1;
              state     <= BLANK;
            end else if (hrefFall) begin
              state <= BLANK;
              phase <= 1'b0;
              y     <= satInc(y);
            end else if (pclkRise) begin
              if (!phase) begin
                byte0 <= camData;
                phase <= 1'b1;
              end else begin
                pixelRed   <= expand5(byte0[7:3]);
                pixelGreen <= expand6({byte0[2:0], camData[7:5]});
                pixelBlue  <= expand5(camData[4:0]);
                pixelX     <= x;
                pixelY     <= y;
                pixelValid <= 1'b1;
                x          <= satInc(x);
                phase      <= 1'b0;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tracker_ctrl.sv
// Self-checking bench for tracker_ctrl: table vectors, directed corner
// sequences and random frames checked against a pixel-list model.
module tb_tracker_ctrl;

  logic       clk = 1'b0;
  logic       resetN;
  logic       camVsync, camHref, camPclk;
  logic [7:0] camData;
  logic       enable, cfgValid, cfgReady;
  logic [7:0] cfgRed, cfgGreen, cfgBlue, cfgThreshold;
  logic [7:0] targetRed, targetGreen, targetBlue, threshold;
  logic       pixelValid;
  logic [7:0] pixelRed, pixelGreen, pixelBlue, pixelX, pixelY;
  logic       frameStart, frameDone, busy;

  tracker_ctrl dut (
    .clk(clk), .resetN(resetN),
    .camVsync(camVsync), .camHref(camHref), .camPclk(camPclk), .camData(camData),
    .enable(enable), .cfgValid(cfgValid), .cfgReady(cfgReady),
    .cfgRed(cfgRed), .cfgGreen(cfgGreen), .cfgBlue(cfgBlue), .cfgThreshold(cfgThreshold),
    .targetRed(targetRed), .targetGreen(targetGreen), .targetBlue(targetBlue),
    .threshold(threshold),
    .pixelValid(pixelValid), .pixelRed(pixelRed), .pixelGreen(pixelGreen),
    .pixelBlue(pixelBlue), .pixelX(pixelX), .pixelY(pixelY),
    .frameStart(frameStart), .frameDone(frameDone), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] r, g, b, x, y;
  } pix_t;

  typedef struct {
    logic [7:0] b0, b1, r, g, b;
  } colorVec_t;

  typedef logic [7:0] byteQ_t[$];

  pix_t captured[$];
  pix_t expected[$];
  int   nStart = 0;
  int   nDone  = 0;
  int   checks = 0;
  int   errors = 0;

  always @(negedge clk) begin
    if (pixelValid) captured.push_back('{pixelRed, pixelGreen, pixelBlue, pixelX, pixelY});
    if (frameStart) nStart++;
    if (frameDone)  nDone++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic pix_t modelPixel(input int b0, input int b1, input int px, input int line);
    int r5, g6, b5;
    pix_t p;
    r5 = b0 >> 3;
    g6 = ((b0 & 7) << 3) | (b1 >> 5);
    b5 = b1 & 31;
    p.r = 8'((r5 << 3) | (r5 >> 2));
    p.g = 8'((g6 << 2) | (g6 >> 4));
    p.b = 8'((b5 << 3) | (b5 >> 2));
    p.x = 8'((px > 255) ? 255 : px);
    p.y = 8'((line > 255) ? 255 : line);
    return p;
  endfunction

  function automatic logic [39:0] packPix(input pix_t p);
    return {p.r, p.g, p.b, p.x, p.y};
  endfunction

  task automatic waitClk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pclkCycle(input logic [7:0] d);
    camData = d;
    waitClk(3);
    camPclk = 1'b1;
    waitClk(5);
    camPclk = 1'b0;
    waitClk(2);
  endtask

  task automatic sendLine(input byteQ_t bytes);
    camHref = 1'b1;
    waitClk(6);
    foreach (bytes[i]) pclkCycle(bytes[i]);
    waitClk(4);
    camHref = 1'b0;
    waitClk(6);
  endtask

  task automatic vsyncPulse();
    camVsync = 1'b1;
    waitClk(8);
    camVsync = 1'b0;
    waitClk(8);
  endtask

  task automatic randomLine(input int nBytes, input int lineIdx);
    byteQ_t q;
    for (int i = 0; i < nBytes; i++) q.push_back(8'($urandom_range(0, 255)));
    for (int p = 0; p < nBytes / 2; p++)
      expected.push_back(modelPixel(int'(q[2*p]), int'(q[2*p+1]), p, lineIdx));
    sendLine(q);
  endtask

  task automatic comparePixels(input string name, input int base);
    int n;
    n = captured.size() - base;
    check({name, "_count"}, 64'(n), 64'(expected.size()));
    for (int i = 0; i < n && i < expected.size(); i++)
      check(name, 64'(packPix(captured[base+i])), 64'(packPix(expected[i])));
    expected.delete();
  endtask

  task automatic cfgWrite(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                          input logic [7:0] t);
    cfgRed = r; cfgGreen = g; cfgBlue = b; cfgThreshold = t;
    cfgValid = 1'b1;
    waitClk(1);
    cfgValid = 1'b0;
  endtask

  task automatic checkTargets(input string name, input logic [31:0] exp);
    check(name, 64'({targetRed, targetGreen, targetBlue, threshold}), 64'(exp));
  endtask

  task automatic checkResetOutputs(input string name);
    check({name, "_pixel"}, 64'({pixelValid, pixelRed, pixelGreen, pixelBlue, pixelX, pixelY}), 64'(0));
    checkTargets({name, "_targets"}, {8'd0, 8'd0, 8'd0, 8'd20});
    check({name, "_pulses"}, 64'({frameStart, frameDone, busy}), 64'(0));
    check({name, "_cfgReady"}, 64'(cfgReady), 64'(1));
  endtask

  colorVec_t vecs[6];

  initial begin
    int base, s0, d0, nLines;
    byteQ_t q;

    vecs[0] = '{8'hF8, 8'h00, 8'd255, 8'd0,   8'd0};
    vecs[1] = '{8'h07, 8'hE0, 8'd0,   8'd255, 8'd0};
    vecs[2] = '{8'h00, 8'h1F, 8'd0,   8'd0,   8'd255};
    vecs[3] = '{8'hFF, 8'hFF, 8'd255, 8'd255, 8'd255};
    vecs[4] = '{8'h00, 8'h00, 8'd0,   8'd0,   8'd0};
    vecs[5] = '{8'h84, 8'h10, 8'd132, 8'd130, 8'd132};

    resetN = 1'b0; camVsync = 1'b0; camHref = 1'b0; camPclk = 1'b0; camData = '0;
    enable = 1'b0; cfgValid = 1'b0;
    cfgRed = '0; cfgGreen = '0; cfgBlue = '0; cfgThreshold = '0;
    waitClk(5);
    checkResetOutputs("reset");
    resetN = 1'b1;
    waitClk(3);
    enable = 1'b1;
    waitClk(3);
    check("busyEnabled", 64'(busy), 64'(1));

    // 4x2 frame
    s0 = nStart; d0 = nDone; base = captured.size();
    vsyncPulse();
    check("frameA_start", 64'(nStart - s0), 64'(1));
    randomLine(8, 0);
    randomLine(8, 1);
    camVsync = 1'b1;
    waitClk(8);
    comparePixels("frameA_pix", base);
    check("frameA_done", 64'(nDone - d0), 64'(1));
    check("frameA_startOnce", 64'(nStart - s0), 64'(1));
    camVsync = 1'b0;
    waitClk(8);

    // colour expansion table on one line
    base = captured.size();
    q.delete();
    for (int i = 0; i < 6; i++) begin
      q.push_back(vecs[i].b0);
      q.push_back(vecs[i].b1);
    end
    sendLine(q);
    check("table_count", 64'(captured.size() - base), 64'(6));
    for (int i = 0; i < 6 && base + i < captured.size(); i++)
      check("table_rgbx",
            64'({captured[base+i].r, captured[base+i].g, captured[base+i].b, captured[base+i].x}),
            64'({vecs[i].r, vecs[i].g, vecs[i].b, 8'(i)}));

    // mid-frame config write is deferred to next frameStart
    check("cfgReadyIdle", 64'(cfgReady), 64'(1));
    cfgWrite(8'd10, 8'd20, 8'd30, 8'd5);
    check("cfgReadyPending", 64'(cfgReady), 64'(0));
    checkTargets("targetsHeld1", {8'd0, 8'd0, 8'd0, 8'd20});
    randomLine(2, 1);
    expected.delete();
    camVsync = 1'b1;
    waitClk(8);
    checkTargets("targetsHeld2", {8'd0, 8'd0, 8'd0, 8'd20});
    check("cfgReadyStillPending", 64'(cfgReady), 64'(0));
    camVsync = 1'b0;
    waitClk(8);
    checkTargets("targetsApplied", {8'd10, 8'd20, 8'd30, 8'd5});
    check("cfgReadyAfterApply", 64'(cfgReady), 64'(1));

    // 300-pixel saturating line, then a 3-byte line
    base = captured.size();
    randomLine(600, 0);
    randomLine(3, 1);
    camVsync = 1'b1;
    waitClk(8);
    comparePixels("longLine_pix", base);
    camVsync = 1'b0;
    waitClk(8);

    // random frames
    for (int f = 0; f < 5; f++) begin
      base = captured.size();
      d0 = nDone;
      nLines = $urandom_range(1, 3);
      for (int l = 0; l < nLines; l++) randomLine($urandom_range(1, 9), l);
      camVsync = 1'b1;
      waitClk(8);
      comparePixels("random_pix", base);
      check("random_done", 64'(nDone - d0), 64'(1));
      camVsync = 1'b0;
      waitClk(8);
    end

    // pending update survives disable
    enable = 1'b0;
    waitClk(3);
    check("busyDisabled", 64'(busy), 64'(0));
    cfgWrite(8'd1, 8'd2, 8'd3, 8'd4);
    check("cfgReadyDisabledPending", 64'(cfgReady), 64'(0));
    enable = 1'b1;
    waitClk(3);
    checkTargets("targetsBeforeReenableStart", {8'd10, 8'd20, 8'd30, 8'd5});
    vsyncPulse();
    checkTargets("targetsAfterReenable", {8'd1, 8'd2, 8'd3, 8'd4});
    check("cfgReadyAfterReenable", 64'(cfgReady), 64'(1));

    // enable dropped mid-line
    base = captured.size();
    camHref = 1'b1;
    waitClk(6);
    for (int i = 0; i < 6; i++) pclkCycle(8'($urandom_range(0, 255)));
    check("dropPre_count", 64'(captured.size() - base), 64'(3));
    base = captured.size(); s0 = nStart; d0 = nDone;
    enable = 1'b0;
    waitClk(1);
    check("dropBusy", 64'({busy, pixelValid}), 64'(0));
    for (int i = 0; i < 8; i++) pclkCycle(8'($urandom_range(0, 255)));
    waitClk(4);
    camHref = 1'b0;
    waitClk(6);
    vsyncPulse();
    check("dropNoPixels", 64'(captured.size() - base), 64'(0));
    check("dropNoPulses", 64'({nStart - s0, nDone - d0}), 64'(0));

    // reset mid-frame
    enable = 1'b1;
    waitClk(3);
    vsyncPulse();
    camHref = 1'b1;
    waitClk(6);
    for (int i = 0; i < 4; i++) pclkCycle(8'($urandom_range(0, 255)));
    resetN = 1'b0;
    #1;
    checkResetOutputs("midReset");
    waitClk(3);
    resetN = 1'b1;
    for (int i = 0; i < 4; i++) pclkCycle(8'($urandom_range(0, 255)));
    waitClk(4);
    camHref = 1'b0;
    waitClk(6);
    base = captured.size(); s0 = nStart; d0 = nDone;
    camVsync = 1'b1;
    waitClk(8);
    check("postReset_noDone", 64'(nDone - d0), 64'(0));
    check("postReset_noStartYet", 64'(nStart - s0), 64'(0));
    camVsync = 1'b0;
    waitClk(8);
    check("postReset_start", 64'(nStart - s0), 64'(1));
    randomLine(4, 0);
    camVsync = 1'b1;
    waitClk(8);
    comparePixels("postReset_pix", base);
    check("postReset_done", 64'(nDone - d0), 64'(1));
    camVsync = 1'b0;
    waitClk(8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
